// File: rtl/imm_splitter_pkg.sv
// Shared constants and FSM state type for the immediate splitter and the
// datapath sign extender it mirrors.
package imm_splitter_pkg;

    localparam int DATA_W = 8;
    localparam int IMM_W  = 3;
    localparam int NCHUNK = (DATA_W + IMM_W - 1) / IMM_W;
    localparam int EXT_W  = NCHUNK * IMM_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage

// File: rtl/imm_splitter_len_calc.sv
// imm_len_calc: number of IMM_W-bit chunks needed to rebuild a signed value
// (smallest k whose k*IMM_W-bit signed range contains the value).
module imm_len_calc #(
    parameter int DATA_W = imm_splitter_pkg::DATA_W,
    parameter int IMM_W  = imm_splitter_pkg::IMM_W,
    localparam int NCHUNK = (DATA_W + IMM_W - 1) / IMM_W,
    localparam int EXT_W  = NCHUNK * IMM_W,
    localparam int CNT_W  = $clog2(NCHUNK + 1)
) (
    input  logic [DATA_W-1:0] value,
    output logic [CNT_W-1:0]  n
);

    logic signed [EXT_W-1:0] ext;
    logic signed [EXT_W-1:0] upper;

    always_comb begin
        ext   = EXT_W'($signed(value));
        upper = '0;
        n     = CNT_W'(NCHUNK);
        // descending scan so the smallest fitting width wins
        for (int k = NCHUNK - 1; k >= 1; k--) begin
            upper = ext >>> (k * IMM_W - 1);
            if ((upper == '0) || (upper == '1)) begin
                n = CNT_W'(k);
            end
        end
    end

endmodule

// File: rtl/imm_splitter.sv
// Splits a signed value into the shortest MSB-first run of IMM_W-bit chunks.
// Optional IMM_SPLIT_STATS_EN adds saturating value/chunk handshake counters.
module imm_splitter #(
    parameter int DATA_W = imm_splitter_pkg::DATA_W,
    parameter int IMM_W  = imm_splitter_pkg::IMM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IMM_W-1:0]  out_imm,
    output logic              out_first,
    output logic              out_last
`ifdef IMM_SPLIT_STATS_EN
    ,
    output logic [15:0]       stat_values,
    output logic [15:0]       stat_chunks
`endif
);

    // state | meaning
    // IDLE  | waiting for a value, in_ready=1
    // EMIT  | presenting chunk idx, count down to 0

    import imm_splitter_pkg::*;

    localparam int NCHUNK = (DATA_W + IMM_W - 1) / IMM_W;
    localparam int EXT_W  = NCHUNK * IMM_W;
    localparam int CNT_W  = $clog2(NCHUNK + 1);

    state_e               state_q, state_d;
    logic [EXT_W-1:0]     ext_q, ext_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     len;
    logic [IMM_W-1:0]     imm_d;
    logic                 valid_d, first_d, last_d;
    logic                 accept, chunk_done;
    logic signed [EXT_W-1:0] ext_in;

    imm_len_calc #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_len (
        .value (in_data),
        .n     (len)
    );

    function automatic logic [IMM_W-1:0] chunk_at(input logic [EXT_W-1:0] e,
                                                  input logic [CNT_W-1:0] i);
        logic [IMM_W-1:0] c;
        c = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (i == CNT_W'(k)) begin
                c = e[k*IMM_W +: IMM_W];
            end
        end
        return c;
    endfunction

    assign ext_in     = EXT_W'($signed(in_data));
    assign in_ready   = (state_q == IDLE);
    assign accept     = in_valid && in_ready;
    assign chunk_done = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        ext_d   = ext_q;
        idx_d   = idx_q;
        imm_d   = out_imm;
        valid_d = out_valid;
        first_d = out_first;
        last_d  = out_last;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ext_d   = ext_in;
                    idx_d   = len - CNT_W'(1);
                    imm_d   = chunk_at(ext_in, len - CNT_W'(1));
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = (len == CNT_W'(1));
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (chunk_done) begin
                    if (idx_q == '0) begin
                        valid_d = 1'b0;
                        imm_d   = '0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q - CNT_W'(1);
                        imm_d   = chunk_at(ext_q, idx_q - CNT_W'(1));
                        first_d = 1'b0;
                        last_d  = (idx_q == CNT_W'(1));
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_q     <= '0;
            idx_q     <= '0;
            out_imm   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            ext_q     <= ext_d;
            idx_q     <= idx_d;
            out_imm   <= imm_d;
            out_valid <= valid_d;
            out_first <= first_d;
            out_last  <= last_d;
        end
    end

`ifdef IMM_SPLIT_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_values <= '0;
            stat_chunks <= '0;
        end else begin
            if (accept && (stat_values != 16'hFFFF)) begin
                stat_values <= stat_values + 16'd1;
            end
            if (chunk_done && (stat_chunks != 16'hFFFF)) begin
                stat_chunks <= stat_chunks + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_splitter.sv
// Scoreboard bench for imm_splitter: directed values with hand-computed chunks,
// stall stability, and mid-sequence reset abort.
module tb_imm_splitter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [2:0] out_imm;
    logic       out_first;
    logic       out_last;
`ifdef IMM_SPLIT_STATS_EN
    logic [15:0] stat_values;
    logic [15:0] stat_chunks;
`endif

    imm_splitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_first (out_first),
        .out_last  (out_last)
`ifdef IMM_SPLIT_STATS_EN
        ,
        .stat_values (stat_values),
        .stat_chunks (stat_chunks)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] imm;
        logic       first;
        logic       last;
        int         val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   acc = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push_val(input logic [7:0] d, input int n, input logic [8:0] ch);
        exp_t e;
        for (int i = n - 1; i >= 0; i--) begin
            e.imm   = ch[i*3 +: 3];
            e.first = (i == n - 1);
            e.last  = (i == 0);
            e.val   = int'($signed(d));
            sb.push_back(e);
        end
    endtask

    // caller is positioned #1 after a rising edge
    task automatic send(input logic [7:0] d);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("send_timeout", 1, 0);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) chk("drain_timeout", 1, 0);
    endtask

    // monitor: pops expected chunk on every output handshake
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_chunk", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("imm", int'(out_imm), int'(e.imm));
                chk("first", int'(out_first), int'(e.first));
                chk("last", int'(out_last), int'(e.last));
                if (out_first) acc = int'($signed(out_imm));
                else           acc = (acc * 8) | int'(out_imm);
                if (out_last) chk("rebuild", acc, e.val);
            end
        end
    end

    logic [7:0] vd[8] = '{8'h02, 8'hFC, 8'h04, 8'h10, 8'h7F, 8'h80, 8'hE0, 8'h20};
    int         vn[8] = '{1, 1, 2, 2, 3, 3, 2, 3};
    logic [8:0] vc[8] = '{9'b000_000_010, 9'b000_000_100, 9'b000_000_100,
                          9'b000_010_000, 9'b001_111_111, 9'b110_000_000,
                          9'b000_100_000, 9'b000_100_000};

    initial begin
        exp_t e;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_imm", int'(out_imm), 0);
        chk("rst_out_first", int'(out_first), 0);
        chk("rst_out_last", int'(out_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single chunk value with latency check
        push_val(vd[0], vn[0], vc[0]);
        send(vd[0]);
        chk("lat_out_valid", int'(out_valid), 1);
        chk("lat_in_ready_busy", int'(in_ready), 0);
        @(posedge clk); #1;
        chk("lat_in_ready_back", int'(in_ready), 1);
        chk("lat_out_valid_drop", int'(out_valid), 0);

        for (int i = 1; i < 8; i++) begin
            push_val(vd[i], vn[i], vc[i]);
            send(vd[i]);
            wait_idle();
        end

        // stall in the middle of 0x7F
        push_val(8'h7F, 3, 9'b001_111_111);
        out_ready = 1'b0;
        send(8'h7F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_imm", int'(out_imm), 3'b111);
            chk("stall_first", int'(out_first), 0);
            chk("stall_last", int'(out_last), 0);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        chk("stall_pending", sb.size(), 2);
        out_ready = 1'b1;
        wait_idle();

        // reset during second chunk of 0x80
        e.imm = 3'b110; e.first = 1'b1; e.last = 1'b0; e.val = -128;
        sb.push_back(e);
        out_ready = 1'b0;
        send(8'h80);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("abort_pre_imm", int'(out_imm), 3'b000);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_sb_empty", sb.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
`ifdef IMM_SPLIT_STATS_EN
        chk("stat_values_rst", int'(stat_values), 0);
        chk("stat_chunks_rst", int'(stat_chunks), 0);
`endif
        push_val(8'h01, 1, 9'b000_000_001);
        send(8'h01);
        wait_idle();
`ifdef IMM_SPLIT_STATS_EN
        chk("stat_values", int'(stat_values), 1);
        chk("stat_chunks", int'(stat_chunks), 1);
`endif
        repeat (3) @(posedge clk);
        chk("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
